// File: rtl/jtvigil_prio_colmix.sv
// Priority colour mixer: picks the winning layer pixel, fetches R/G/B from a byte-wide palette RAM
// and drives blanked RGB. Optional brightness halving under `JTVIGIL_COLMIX_DIM_EN.
module jtvigil_prio_colmix #(
  parameter int unsigned LAYERS = 2,
  parameter int unsigned PXLW   = 8,
  parameter int unsigned CW     = 5,
  parameter int unsigned LSW    = 1,
  parameter int unsigned AW     = 2 + LSW + PXLW
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic [LAYERS-1:0]      layer_top,
  input  logic [LAYERS-1:0]      gfx_en,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [7:0]             cpu_dout,
  input  logic                   cpu_we,
  output logic [7:0]             cpu_din,
  input  logic                   dim,
  output logic [CW-1:0]          red,
  output logic [CW-1:0]          green,
  output logic [CW-1:0]          blue
);

  localparam int unsigned WINW  = LSW + PXLW;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {IDLE, RD_R, RD_G, RD_B, CAP_B} state_t;

  state_t            state_q, state_d;
  logic [WINW-1:0]   win_q, win_c;
  logic              blank_q;
  logic [CW-1:0]     pre_r, pre_g, pre_b;
  logic [CW-1:0]     q;
  logic [AW-1:0]     vaddr;
  logic [7:0]        mem [DEPTH];

  // Winner: topped opaque layers beat all others; among equals the higher index wins
  logic            has_top, has_any;
  logic [LSW-1:0]  top_idx, any_idx;
  logic [PXLW-1:0] top_pxl, any_pxl;

  always_comb begin
    has_top = 1'b0;
    has_any = 1'b0;
    top_idx = '0;
    any_idx = '0;
    top_pxl = '0;
    any_pxl = '0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (gfx_en[i] && (layer_pxl[i*PXLW +: 4] != 4'd0)) begin
        has_any = 1'b1;
        any_idx = LSW'(i);
        any_pxl = layer_pxl[i*PXLW +: PXLW];
        if (layer_top[i]) begin
          has_top = 1'b1;
          top_idx = LSW'(i);
          top_pxl = layer_pxl[i*PXLW +: PXLW];
        end
      end
    end
    if (has_top)      win_c = {top_idx, top_pxl};
    else if (has_any) win_c = {any_idx, any_pxl};
    else              win_c = {LSW'(0), layer_pxl[PXLW-1:0]};
  end

  function automatic logic [CW-1:0] shade(input logic [CW-1:0] v, input logic half);
`ifdef JTVIGIL_COLMIX_DIM_EN
    return half ? (v >> 1) : v;
`else
    logic unused_half;
    unused_half = half;
    return v;
`endif
  endfunction

  // Next state and video read address
  always_comb begin
    state_d = state_q;
    vaddr   = '0;
    case (state_q)
      IDLE:  state_d = IDLE;
      RD_R:  begin state_d = RD_G;  vaddr = {2'd0, win_q}; end
      RD_G:  begin state_d = RD_B;  vaddr = {2'd1, win_q}; end
      RD_B:  begin state_d = CAP_B; vaddr = {2'd2, win_q}; end
      CAP_B: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pxl_cen) state_d = RD_R;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Plane capture, pixel latch and output update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r   <= '0;
      pre_g   <= '0;
      pre_b   <= '0;
      win_q   <= '0;
      blank_q <= 1'b1;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      if (state_q == RD_G)  pre_r <= q;
      if (state_q == RD_B)  pre_g <= q;
      if (state_q == CAP_B) pre_b <= q;
      if (pxl_cen) begin
        win_q   <= win_c;
        blank_q <= !LHBL || !LVBL;
        red     <= blank_q ? '0 : shade(pre_r, dim);
        green   <= blank_q ? '0 : shade(pre_g, dim);
        // a restart coinciding with CAP_B still shows the blue being captured
        blue    <= blank_q ? '0 : shade((state_q == CAP_B) ? q : pre_b, dim);
      end
    end
  end

  // Dual-port palette: read-first on both ports
  always_ff @(posedge clk) begin
    q       <= mem[vaddr][CW-1:0];
    cpu_din <= mem[cpu_addr];
    if (cpu_we) mem[cpu_addr] <= cpu_dout;
  end

endmodule

// File: tb/tb_jtvigil_prio_colmix.sv
// Bench for jtvigil_prio_colmix: directed scenarios plus randomized pixels against a palette/priority model.
module tb_jtvigil_prio_colmix;

  logic        rst, clk, pxl_cen, LHBL, LVBL, cpu_we, dim;
  logic [15:0] layer_pxl;
  logic [1:0]  layer_top, gfx_en;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_dout, cpu_din;
  logic [4:0]  red, green, blue;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  pal [2048];
  logic [4:0]  cur_r, cur_g, cur_b;
  logic        cur_blank;
  logic [14:0] exp_rgb;

  jtvigil_prio_colmix dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .layer_pxl(layer_pxl), .layer_top(layer_top), .gfx_en(gfx_en),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .dim(dim), .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [4:0] shade(input logic [4:0] v, input logic half);
`ifdef JTVIGIL_COLMIX_DIM_EN
    return half ? v / 2 : v;
`else
    return half ? v : v;
`endif
  endfunction

  // Spec rules: topped opaque wins (highest index), else highest opaque, else layer 0 raw
  function automatic logic [8:0] model_win(input logic [15:0] px, input logic [1:0] top, input logic [1:0] en);
    int any = -1;
    int tp  = -1;
    int sel;
    for (int i = 0; i < 2; i++)
      if (en[i] && px[i*8 +: 4] != 4'd0) begin
        any = i;
        if (top[i]) tp = i;
      end
    sel = (tp >= 0) ? tp : ((any >= 0) ? any : 0);
    return {1'(sel), px[sel*8 +: 8]};
  endfunction

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    pal[a] = d;
  endtask

  // Issue one pxl_cen; exp_rgb becomes what the outputs show from this edge on
  task automatic drive_pxl(input logic [15:0] px, input logic [1:0] top, input logic [1:0] en,
                           input logic hbl, input logic vbl);
    logic [8:0] w;
    exp_rgb = cur_blank ? 15'd0 : {shade(cur_r, dim), shade(cur_g, dim), shade(cur_b, dim)};
    w = model_win(px, top, en);
    cur_r = pal[{2'd0, w}][4:0];
    cur_g = pal[{2'd1, w}][4:0];
    cur_b = pal[{2'd2, w}][4:0];
    cur_blank = !hbl || !vbl;
    layer_pxl = px; layer_top = top; gfx_en = en; LHBL = hbl; LVBL = vbl;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
  endtask

  task automatic pix(input logic [15:0] px, input logic [1:0] top, input logic [1:0] en);
    drive_pxl(px, top, en, 1'b1, 1'b1);
    idle(5);
  endtask

  task automatic test_reset();
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; cpu_we = 1'b0; dim = 1'b0;
    layer_pxl = '0; layer_top = '0; gfx_en = 2'b11; cpu_addr = '0; cpu_dout = '0;
    cur_r = '0; cur_g = '0; cur_b = '0; cur_blank = 1'b1;
    idle(3);
    n_tests++;
    if ({red, green, blue} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", {red, green, blue});
    end
    rst = 1'b0;
    tick();
    for (int a = 0; a < 2048; a++) cpu_write(11'(a), 8'($urandom));
    pix(16'h0000, 2'b00, 2'b11);
    n_tests++;
    if ({red, green, blue} !== 15'd0) begin
      n_fail++; $display("FAIL reset_first_pixel got=%h exp=0", {red, green, blue});
    end
  endtask

  task automatic test_priority();
    cpu_write(11'h105, 8'h1F); cpu_write(11'h305, 8'h0A); cpu_write(11'h505, 8'h03);
    cpu_write(11'h007, 8'hE5); cpu_write(11'h207, 8'h02); cpu_write(11'h407, 8'h1C);
    pix(16'h0507, 2'b00, 2'b11);
    pix(16'h0507, 2'b01, 2'b11);
    n_tests++;
    if ({red, green, blue} !== {5'd31, 5'd10, 5'd3}) begin
      n_fail++; $display("FAIL prio_highest got=%h exp=%h", {red, green, blue}, {5'd31, 5'd10, 5'd3});
    end
    pix(16'h0507, 2'b01, 2'b10);
    n_tests++;
    if ({red, green, blue} !== {5'd5, 5'd2, 5'd28}) begin
      n_fail++; $display("FAIL prio_top got=%h exp=%h", {red, green, blue}, {5'd5, 5'd2, 5'd28});
    end
    pix(16'h0000, 2'b00, 2'b11);
    n_tests++;
    if ({red, green, blue} !== {5'd31, 5'd10, 5'd3}) begin
      n_fail++; $display("FAIL prio_gfx_en got=%h exp=%h", {red, green, blue}, {5'd31, 5'd10, 5'd3});
    end
  endtask

  task automatic test_background_blank();
    cpu_write(11'h030, 8'h09); cpu_write(11'h230, 8'h14); cpu_write(11'h430, 8'h0F);
    pix(16'h5030, 2'b00, 2'b11);
    drive_pxl(16'h5030, 2'b00, 2'b11, 1'b0, 1'b1);
    idle(5);
    n_tests++;
    if ({red, green, blue} !== {5'd9, 5'd20, 5'd15}) begin
      n_fail++; $display("FAIL bg_colour got=%h exp=%h", {red, green, blue}, {5'd9, 5'd20, 5'd15});
    end
    drive_pxl(16'h0507, 2'b00, 2'b11, 1'b1, 1'b0);
    idle(5);
    n_tests++;
    if ({red, green, blue} !== 15'd0) begin
      n_fail++; $display("FAIL hblank got=%h exp=0", {red, green, blue});
    end
    pix(16'h0000, 2'b00, 2'b11);
    n_tests++;
    if ({red, green, blue} !== 15'd0) begin
      n_fail++; $display("FAIL vblank got=%h exp=0", {red, green, blue});
    end
  endtask

  task automatic test_collision();
    cpu_write(11'h040, 8'h01); cpu_write(11'h240, 8'h07); cpu_write(11'h440, 8'h02);
    cpu_write(11'h6AB, 8'h6A);
    pix(16'h0040, 2'b00, 2'b11);
    drive_pxl(16'h0040, 2'b00, 2'b11, 1'b1, 1'b1);
    tick();
    cpu_addr = 11'h240; cpu_dout = 8'h12; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0; pal[11'h240] = 8'h12;
    tick();
    n_tests++;
    if (cpu_din !== 8'h12) begin
      n_fail++; $display("FAIL cpu_raw got=%h exp=12", cpu_din);
    end
    cpu_addr = 11'h6AB;
    tick();
    n_tests++;
    if (cpu_din !== 8'h6A) begin
      n_fail++; $display("FAIL cpu_plane3 got=%h exp=6a", cpu_din);
    end
    idle(2);
    pix(16'h0040, 2'b00, 2'b11);
    n_tests++;
    if ({red, green, blue} !== {5'd1, 5'd7, 5'd2}) begin
      n_fail++; $display("FAIL collision_old got=%h exp=%h", {red, green, blue}, {5'd1, 5'd7, 5'd2});
    end
    pix(16'h0000, 2'b00, 2'b11);
    n_tests++;
    if ({red, green, blue} !== {5'd1, 5'd18, 5'd2}) begin
      n_fail++; $display("FAIL collision_new got=%h exp=%h", {red, green, blue}, {5'd1, 5'd18, 5'd2});
    end
  endtask

  task automatic test_dim();
    pix(16'h0507, 2'b00, 2'b11);
    dim = 1'b1;
    pix(16'h0000, 2'b00, 2'b11);
    dim = 1'b0;
    n_tests++;
`ifdef JTVIGIL_COLMIX_DIM_EN
    if (red !== 5'd15) begin
      n_fail++; $display("FAIL dim_red got=%0d exp=15", red);
    end
`else
    if (red !== 5'd31) begin
      n_fail++; $display("FAIL dim_red got=%0d exp=31", red);
    end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    pix(16'h0507, 2'b00, 2'b11);
    drive_pxl(16'h0507, 2'b00, 2'b11, 1'b1, 1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({red, green, blue} !== 15'd0) begin
      n_fail++; $display("FAIL rst_mid_fetch got=%h exp=0", {red, green, blue});
    end
    tick();
    rst = 1'b0;
    cur_blank = 1'b1;
    idle(2);
    pix(16'h0507, 2'b00, 2'b11);
    n_tests++;
    if ({red, green, blue} !== 15'd0) begin
      n_fail++; $display("FAIL rst_after_first got=%h exp=0", {red, green, blue});
    end
    pix(16'h0000, 2'b00, 2'b11);
    n_tests++;
    if ({red, green, blue} !== {5'd31, 5'd10, 5'd3}) begin
      n_fail++; $display("FAIL rst_refetch got=%h exp=%h", {red, green, blue}, {5'd31, 5'd10, 5'd3});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      dim = 1'($urandom);
      drive_pxl(16'($urandom), 2'($urandom), 2'($urandom_range(3, 0) == 0 ? 1 : 3),
                1'($urandom_range(7, 0) != 0), 1'($urandom_range(7, 0) != 0));
      idle(4 + $urandom_range(3, 1));
      n_tests++;
      if ({red, green, blue} !== exp_rgb) begin
        n_fail++; $display("FAIL random_%0d got=%h exp=%h", k, {red, green, blue}, exp_rgb);
      end
    end
    dim = 1'b0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_background_blank();
    test_collision();
    test_dim();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
